// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock generator: programmable half-period divider,
// transfer-length counter and CPOL/CPHA-resolved sample/shift strobes.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  output logic             sclk,
  output logic             sample_stb,
  output logic             shift_stb,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic             sclk_q,   sclk_d;
  logic             smp_q,    smp_d;
  logic             shf_q,    shf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             cpol_s_q, cpol_s_d;
  logic             cpha_s_q, cpha_s_d;
  logic [DIV_W-1:0] div_s_q,  div_s_d;
  logic [CNT_W-1:0] nbits_s_q, nbits_s_d;
  logic [DIV_W-1:0] half_q,   half_d;
  logic [CNT_W:0]   edge_q,   edge_d;

  logic [CNT_W:0]   edge_inc;
  logic             leading;
  logic             last_edge;

  assign edge_inc  = edge_q + (CNT_W+1)'(1);
  assign leading   = edge_inc[0];
  assign last_edge = (edge_inc == {nbits_s_q, 1'b0});

  // Next-state logic: idle tracking of CPOL, half-period countdown and edge generation.
  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    smp_d     = 1'b0;
    shf_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cpol_s_d  = cpol_s_q;
    cpha_s_d  = cpha_s_q;
    div_s_d   = div_s_q;
    nbits_s_d = nbits_s_q;
    half_d    = half_q;
    edge_d    = edge_q;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start) begin
          if (nbits != '0) begin
            cpol_s_d  = cpol;
            cpha_s_d  = cpha;
            div_s_d   = div;
            nbits_s_d = nbits;
            half_d    = div;
            edge_d    = '0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (abort) begin
          sclk_d  = cpol_s_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (half_q != '0) begin
          half_d = half_q - DIV_W'(1);
        end else begin
          sclk_d = ~sclk_q;
          half_d = div_s_q;
          edge_d = edge_inc;
          // Leading edges sample when CPHA=0 and shift when CPHA=1.
          smp_d  = leading ^ cpha_s_q;
          shf_d  = ~(leading ^ cpha_s_q);
          if (last_edge) begin
            sclk_d  = cpol_s_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset; sclk tracks cpol while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sclk_q    <= cpol;
      smp_q     <= 1'b0;
      shf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpol_s_q  <= 1'b0;
      cpha_s_q  <= 1'b0;
      div_s_q   <= '0;
      nbits_s_q <= '0;
      half_q    <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      smp_q     <= smp_d;
      shf_q     <= shf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpol_s_q  <= cpol_s_d;
      cpha_s_q  <= cpha_s_d;
      div_s_q   <= div_s_d;
      nbits_s_q <= nbits_s_d;
      half_q    <= half_d;
      edge_q    <= edge_d;
    end
  end

  assign sclk       = sclk_q;
  assign sample_stb = smp_q;
  assign shift_stb  = shf_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Parametrised SPI master serial-clock generator.
- Replaces the fixed /2, /4, /16, /32 divider-and-mux with a programmable half-period divider and a transfer-length counter.
- Generates exactly 2*nbits SCLK edges per transfer, then returns to the CPOL idle level.
- Emits per-edge sample/shift strobes, resolved from CPOL/CPHA, that drive the SPI shift register in the clk domain.

Parameters:
- DIV_W, 8: width of the half-period divider value; half period = div+1 clk cycles.
- CNT_W, 6: width of the bit-count input; max transfer length = 2^CNT_W-1 bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  request a transfer; sampled only in IDLE.
- abort  input  1  terminate the transfer in progress.
- cpol  input  1  SCLK idle level.
- cpha  input  1  clock phase: 0 = sample on leading edge, 1 = shift on leading edge.
- div  input  DIV_W  half-period minus one, in clk cycles.
- nbits  input  CNT_W  number of bits in the transfer.
- sclk  output  1  serial clock, registered.
- sample_stb  output  1  one-cycle pulse: the SCLK edge just produced is a sample edge.
- shift_stb  output  1  one-cycle pulse: the SCLK edge just produced is a shift edge.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset is synchronous and active-high, on clock clk.
  - During reset: sclk=cpol, busy=0, done=0, sample_stb=0, shift_stb=0, state=IDLE, counters=0.
- States: IDLE, RUN.
- IDLE:
  - sclk<=cpol every cycle, so a cpol change is visible one cycle later.
  - Strobes 0.
  - start=1 and nbits!=0: at that edge (E0), latch cpol, cpha, div, nbits into shadow registers, load half-cnt=div, edge-cnt=0, busy<=1, go to RUN.
  - start=1 and nbits==0: no edges; done<=1 for one cycle; busy stays 0.
- RUN, each cycle:
  - half-cnt!=0: decrement half-cnt.
  - half-cnt==0: toggle sclk, reload half-cnt=div, increment edge-cnt.
- Edge timing: edge k (k=1..2N) toggles sclk at edge E0 + k*(div+1).
  - SCLK period is 2*(div+1) clk cycles.
  - div=0 gives clk/2; div=255 gives clk/512.
- Strobes are registered at the same edge that updates sclk, so they are high in the cycle sclk shows its new level.
  - Odd k = leading edge, even k = trailing edge.
  - cpha=0: leading -> sample_stb, trailing -> shift_stb.
  - cpha=1: leading -> shift_stb, trailing -> sample_stb.
  - Never both strobes in the same cycle.
- Completion: at the toggle for k=2N:
  - sclk returns to latched cpol.
  - busy<=0 at that edge and state<=IDLE.
  - done<=1 for exactly the next cycle.
- Configuration changes during RUN (cpol, cpha, div, nbits) have no effect; the shadow registers are used.
- start during RUN is ignored; it is not queued.
- abort during RUN (priority over edge generation):
  - At that edge: sclk<=latched cpol, busy<=0, strobes 0, state IDLE.
  - No done pulse.
- abort in IDLE has no effect.
- start and abort both high in IDLE: start wins (abort only acts in RUN).
- Reset mid-transfer: immediate return to reset values at that edge; no done.
- Width rules:
  - edge-cnt is CNT_W+1 bits, so 2*(2^CNT_W-1) edges fit without wrap.
  - half-cnt is DIV_W bits and never underflows (reload at 0).
- Back-to-back transfers:
  - start may be asserted in the cycle done is high.
  - The next transfer's E0 is that edge, giving a minimum idle of one clk cycle between transfers.

Test Plan:
- Reset with cpol=1 -> sclk=1, busy=0, done=0 during reset and after release with no start.
- cpol=0, cpha=0, div=1, nbits=8, start pulse at E0 ->
  - sclk toggles at E0+2, E0+4, …, E0+32 (16 edges);
  - sample_stb 8 times on rising edges, shift_stb 8 times on falling edges;
  - done single pulse after E0+32; sclk ends at 0.
- cpol=1, cpha=1, div=0, nbits=3 ->
  - 6 toggles at E0+1..E0+6;
  - shift_stb on falling (leading), sample_stb on rising (trailing);
  - sclk idles at 1; busy low after E0+6.
- div=3, nbits=4, abort asserted after 3 edges -> sclk returns to cpol at that edge, busy=0, no done, no further strobes; a new start then produces a full 8-edge transfer.
- nbits=0 start -> done pulse next cycle, no sclk edges, no strobes; also start during RUN and div/cpol changes mid-transfer -> no effect on the edge count or timing.
- Back-to-back: start held high continuously with nbits=2, div=0 -> transfers of 4 edges each, separated by one idle cycle; done pulses once per transfer.
